jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
- Synthesizable automatic player for the memory game; it drives the game's `jogar`/`botoes` inputs and reads back its `leds`/`ganhou`/`perdeu`/`timeout` outputs.
- It watches the LED sequence shown each round, stores it, then replays it as button pulses. It can deliberately inject a wrong press in a chosen round.
- It is used on the board for self-demo and as a reusable stimulus agent in system benches.

Parameters:
- MAX_ROUNDS, 16: number of rounds in a full game; replay memory depth.
- ADDR_W, 4: width of the sequence index; 2^ADDR_W must be >= MAX_ROUNDS.
- JOGAR_CYCLES, 2: cycles `jogar` is held high when a game starts.
- PRESS_CYCLES, 2: cycles each button is held high.
- RELEASE_CYCLES, 2: cycles `botoes` is held at 0 after each press.
- SETTLE_CYCLES, 4: cycles `leds` must stay 0 after the last shown LED before the first press.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  one-cycle start request
- inject_error  in  1  enables error injection
- error_round  in  ADDR_W  0-based round in which the first press is corrupted
- leds  in  4  game LED outputs (one-hot while lit, 0 between LEDs)
- ganhou  in  1  game won
- perdeu  in  1  game lost
- timeout  in  1  game timeout
- jogar  out  1  start pulse to the game
- botoes  out  4  button drive to the game
- ocupado  out  1  high in every state except IDLE and DONE
- fim  out  1  high in DONE
- resultado  out  2  00 none, 01 won, 10 lost, 11 timeout
- erro_leds  out  1  sticky: a non-one-hot LED value was observed
- db_rodada  out  ADDR_W  current 0-based round
- db_estado  out  4  state encoding

Behaviour:
- Reset (asynchronous, any time, including mid-press):
  - State goes to IDLE.
  - All outputs go to 0; all counters go to 0; `erro_leds` is cleared.
  - Memory contents are don't-care.
- States: IDLE, START, OBSERVE, SETTLE, PRESS, RELEASE, NEXT, WAIT_END, DONE.
- IDLE:
  - `iniciar`=1 → START; round=0, obs_idx=0, `resultado`=00.
  - `iniciar` is ignored in all states except IDLE and DONE.
- START:
  - `jogar`=1 for exactly JOGAR_CYCLES cycles, then → OBSERVE.
- OBSERVE:
  - `leds` is registered once (`leds_q`). An LED event is `leds`!=0 and `leds_q`==0.
  - On each event: mem[obs_idx] <= `leds`, obs_idx++. If `leds` is not one-hot, set `erro_leds`.
  - When obs_idx == round+1 → SETTLE.
- SETTLE:
  - Counts consecutive cycles with `leds`==0; any nonzero `leds` restarts the count.
  - After SETTLE_CYCLES zero cycles → PRESS; play_idx=0.
- PRESS:
  - `botoes` = mem[play_idx] for PRESS_CYCLES cycles.
  - Exception: if `inject_error`=1, round == `error_round` and play_idx == 0, drive mem[0] rotated left by one bit (0001→0010, 1000→0001).
  - Then → RELEASE.
- RELEASE:
  - `botoes`=0 for RELEASE_CYCLES cycles.
  - Then, if play_idx == round → NEXT; else play_idx++ and → PRESS.
- NEXT:
  - If round == MAX_ROUNDS-1 → WAIT_END.
  - Else round++, obs_idx=0, → OBSERVE.
  - `leds` are not sampled during PRESS, RELEASE or NEXT, so the game's button echo is ignored. `leds_q` is reloaded with the current `leds` on entry to OBSERVE.
- WAIT_END: idles until a terminal input arrives.
- Terminal inputs (priority `ganhou` > `perdeu` > `timeout`), checked in every state except IDLE and DONE:
  - On the next edge → DONE, `botoes`=0, `jogar`=0.
  - `resultado` = 01 / 10 / 11 respectively; it holds until the next start or reset.
  - A terminal input takes priority over every other transition in the same cycle, including mid-press.
- DONE:
  - `fim`=1.
  - `iniciar` → START; `resultado` and `erro_leds` are cleared, round=0.
- Widths: round, obs_idx and play_idx are ADDR_W bits and never exceed MAX_ROUNDS-1. Timing counters are sized to the largest cycle parameter.
- Outputs are registered; `botoes` changes only on clock edges.

Test Plan:
- Round 1, LED sequence 0100, no injection → `jogar` high 2 cycles; after 4 zero cycles `botoes`=0100 for 2 cycles, then 0 for 2 cycles; game reports `ganhou` in a 1-round configuration → `resultado`=01, `fim`=1.
- `inject_error`=1, `error_round`=0, shown LED 0001 → press 0010; game asserts `perdeu` → `resultado`=10, `botoes`=0, DONE.
- 3-round sequence 0001, 1000, 0010, no injection → replays 1, 2 and 3 presses in order; round 3 presses are 0001, 1000, 0010; `db_rodada` steps 0→1→2.
- `timeout` and `perdeu` asserted in the same cycle mid-PRESS → `resultado`=10; `botoes` is 0 on the next edge.
- LED value 0110 observed → `erro_leds`=1 and stays set through DONE; cleared by the next `iniciar`.
- `reset` asserted during a PRESS with `botoes`=1000 → all outputs go to 0 immediately without a clock edge; the next `iniciar` runs from round 0.

Source files
------------

// File: rtl/jogador_automatico_if.sv
`default_nettype none
// ============================================================================
// Module      : jogador_automatico_if
// Description : Signals between the automatic player and the memory game.
//               master : the player (drives jogar/botoes, reads game status)
//               slave  : the game   (drives leds/ganhou/perdeu/timeout)
//   jogar   - start pulse to the game
//   botoes  - button drive to the game (4 bits)
//   leds    - game LED outputs, one-hot while lit, 0 between LEDs
//   ganhou  - game won
//   perdeu  - game lost
//   timeout - game timed out
// Revision    : 1.0 - initial release
// ============================================================================
interface jogador_automatico_if;
    logic       jogar;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;

    modport master (
        output jogar,
        output botoes,
        input  leds,
        input  ganhou,
        input  perdeu,
        input  timeout
    );

    modport slave (
        input  jogar,
        input  botoes,
        output leds,
        output ganhou,
        output perdeu,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/jogador_automatico.sv
`default_nettype none
// ============================================================================
// Module      : jogador_automatico
// Description : Automatic player for the memory game. Starts a game, watches
//               the LED sequence shown each round, stores it and replays it as
//               timed button presses. Can corrupt the first press of a chosen
//               round to force a loss.
// Ports       :
//   clock, reset  - clock and asynchronous active-high reset
//   iniciar       - one-cycle start request (honoured in IDLE and DONE)
//   inject_error  - enables error injection
//   error_round   - 0-based round whose first press is rotated left by one
//   game          - game-side signals (jogar/botoes out, leds/status in)
//   ocupado       - high in every state except IDLE and DONE
//   fim           - high in DONE
//   resultado     - 00 none, 01 won, 10 lost, 11 timeout
//   erro_leds     - sticky flag: a non-one-hot LED value was observed
//   db_rodada     - current 0-based round
//   db_estado     - state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module jogador_automatico #(
    parameter int MAX_ROUNDS     = 16,
    parameter int ADDR_W         = 4,
    parameter int JOGAR_CYCLES   = 2,
    parameter int PRESS_CYCLES   = 2,
    parameter int RELEASE_CYCLES = 2,
    parameter int SETTLE_CYCLES  = 4
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              iniciar,
    input  wire logic              inject_error,
    input  wire logic [ADDR_W-1:0] error_round,
    jogador_automatico_if.master   game,
    output logic                   ocupado,
    output logic                   fim,
    output logic [1:0]             resultado,
    output logic                   erro_leds,
    output logic [ADDR_W-1:0]      db_rodada,
    output logic [3:0]             db_estado
);

    // Timing counter is sized for the longest of the cycle parameters.
    localparam int c_max_ab  = (JOGAR_CYCLES > PRESS_CYCLES) ? JOGAR_CYCLES : PRESS_CYCLES;
    localparam int c_max_cd  = (RELEASE_CYCLES > SETTLE_CYCLES) ? RELEASE_CYCLES : SETTLE_CYCLES;
    localparam int c_max_cyc = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_cnt_w-1:0] c_jogar_last   = c_cnt_w'(JOGAR_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_press_last   = c_cnt_w'(PRESS_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_release_last = c_cnt_w'(RELEASE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last  = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_last_round   = ADDR_W'(MAX_ROUNDS - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_OBSERVE  = 4'd2,
        S_SETTLE   = 4'd3,
        S_PRESS    = 4'd4,
        S_RELEASE  = 4'd5,
        S_NEXT     = 4'd6,
        S_WAIT_END = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t              r_state, w_state_n;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_n;
    logic [ADDR_W-1:0]   r_round, w_round_n;
    logic [ADDR_W-1:0]   r_obs_idx, w_obs_n;
    logic [ADDR_W-1:0]   r_play_idx, w_play_n;
    logic                r_seen_all, w_seen_n;
    logic [1:0]          r_resultado, w_result_n;
    logic                r_erro_leds, w_erro_n;
    logic                r_jogar;
    logic [3:0]          r_botoes;
    logic                r_ocupado;
    logic                r_fim;
    logic [3:0]          r_leds_q;
    logic                w_mem_we;
    logic [3:0]          r_mem [MAX_ROUNDS];

    logic                w_active;
    logic                w_terminal;
    logic                w_led_event;
    logic                w_onehot;
    logic [3:0]          w_mem_rd;
    logic                w_inject;
    logic [3:0]          w_press_val;

    assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_terminal  = game.ganhou || game.perdeu || game.timeout;
    // Rising "something lit" edge; leds_q tracks leds every cycle, so on entry
    // to OBSERVE it already holds the value seen in the preceding cycle.
    assign w_led_event = (game.leds != 4'b0000) && (r_leds_q == 4'b0000);
    assign w_onehot    = (game.leds != 4'b0000) && ((game.leds & (game.leds - 4'b0001)) == 4'b0000);

    // Button value for the press about to be driven (indexed by next play_idx).
    assign w_mem_rd    = r_mem[w_play_n];
    assign w_inject    = inject_error && (r_round == error_round) && (w_play_n == '0);
    assign w_press_val = w_inject ? {w_mem_rd[2:0], w_mem_rd[3]} : w_mem_rd;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = '0;
        w_round_n  = r_round;
        w_obs_n    = r_obs_idx;
        w_play_n   = r_play_idx;
        w_seen_n   = r_seen_all;
        w_result_n = r_resultado;
        w_erro_n   = r_erro_leds;
        w_mem_we   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (iniciar) begin
                    w_state_n  = S_START;
                    w_round_n  = '0;
                    w_obs_n    = '0;
                    w_play_n   = '0;
                    w_result_n = 2'b00;
                    w_erro_n   = 1'b0;
                end
            end
            S_START: begin
                if (r_cnt == c_jogar_last) begin
                    w_state_n = S_OBSERVE;
                    w_seen_n  = 1'b0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_OBSERVE: begin
                // The last LED of the round raises seen_all instead of pushing
                // obs_idx past round, keeping it inside MAX_ROUNDS-1.
                if (r_seen_all) begin
                    w_state_n = S_SETTLE;
                end else if (w_led_event) begin
                    w_mem_we = 1'b1;
                    if (!w_onehot) begin
                        w_erro_n = 1'b1;
                    end
                    if (r_obs_idx == r_round) begin
                        w_seen_n = 1'b1;
                    end else begin
                        w_obs_n = r_obs_idx + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (game.leds != 4'b0000) begin
                    w_cnt_n = '0;
                end else if (r_cnt == c_settle_last) begin
                    w_state_n = S_PRESS;
                    w_play_n  = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_PRESS: begin
                if (r_cnt == c_press_last) begin
                    w_state_n = S_RELEASE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == c_release_last) begin
                    if (r_play_idx == r_round) begin
                        w_state_n = S_NEXT;
                    end else begin
                        w_play_n  = r_play_idx + 1'b1;
                        w_state_n = S_PRESS;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (r_round == c_last_round) begin
                    w_state_n = S_WAIT_END;
                end else begin
                    w_round_n = r_round + 1'b1;
                    w_obs_n   = '0;
                    w_seen_n  = 1'b0;
                    w_state_n = S_OBSERVE;
                end
            end
            S_WAIT_END: begin
                w_state_n = S_WAIT_END;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Game end overrides any other transition, including mid-press.
        if (w_active && w_terminal) begin
            w_state_n = S_DONE;
            w_cnt_n   = '0;
            if (game.ganhou) begin
                w_result_n = 2'b01;
            end else if (game.perdeu) begin
                w_result_n = 2'b10;
            end else begin
                w_result_n = 2'b11;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_round     <= '0;
            r_obs_idx   <= '0;
            r_play_idx  <= '0;
            r_seen_all  <= 1'b0;
            r_resultado <= 2'b00;
            r_erro_leds <= 1'b0;
            r_jogar     <= 1'b0;
            r_botoes    <= 4'b0000;
            r_ocupado   <= 1'b0;
            r_fim       <= 1'b0;
            r_leds_q    <= 4'b0000;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_round     <= w_round_n;
            r_obs_idx   <= w_obs_n;
            r_play_idx  <= w_play_n;
            r_seen_all  <= w_seen_n;
            r_resultado <= w_result_n;
            r_erro_leds <= w_erro_n;
            r_jogar     <= (w_state_n == S_START);
            r_botoes    <= (w_state_n == S_PRESS) ? w_press_val : 4'b0000;
            r_ocupado   <= (w_state_n != S_IDLE) && (w_state_n != S_DONE);
            r_fim       <= (w_state_n == S_DONE);
            r_leds_q    <= game.leds;
        end
    end

    // Replay memory needs no reset; every entry is written before it is read.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_obs_idx] <= game.leds;
        end
    end

    assign game.jogar  = r_jogar;
    assign game.botoes = r_botoes;
    assign ocupado     = r_ocupado;
    assign fim         = r_fim;
    assign resultado   = r_resultado;
    assign erro_leds   = r_erro_leds;
    assign db_rodada   = r_round;
    assign db_estado   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jogador_automatico.sv
`default_nettype none
// ============================================================================
// Module      : tb_jogador_automatico
// Description : Directed self-checking bench for jogador_automatico. The bench
//               plays the game side: shows LED sequences, watches the replayed
//               presses and raises ganhou/perdeu/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jogador_automatico;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar;
    logic              inject_error;
    logic [ADDR_W-1:0] error_round;
    logic              ocupado;
    logic              fim;
    logic [1:0]        resultado;
    logic              erro_leds;
    logic [ADDR_W-1:0] db_rodada;
    logic [3:0]        db_estado;

    jogador_automatico_if game_if();

    int         checks   = 0;
    int         failures = 0;
    int         gap;
    int         pwidth;
    int         jc;
    logic [3:0] pval;
    logic [3:0] seq [0:2];

    always #5 clock = ~clock;

    jogador_automatico #(
        .MAX_ROUNDS     (16),
        .ADDR_W         (ADDR_W),
        .JOGAR_CYCLES   (2),
        .PRESS_CYCLES   (2),
        .RELEASE_CYCLES (2),
        .SETTLE_CYCLES  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .inject_error (inject_error),
        .error_round  (error_round),
        .game         (game_if),
        .ocupado      (ocupado),
        .fim          (fim),
        .resultado    (resultado),
        .erro_leds    (erro_leds),
        .db_rodada    (db_rodada),
        .db_estado    (db_estado)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the DUT reports a given state.
    task automatic wait_state(input logic [3:0] st, input string tag);
        int n = 0;
        while (db_estado != st && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (db_estado != st) check(tag, db_estado, st);
    endtask

    // Pulse iniciar and count the cycles jogar is seen high.
    task automatic start_game(output int jcount);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        jcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (game_if.jogar) jcount++;
            @(negedge clock);
        end
    endtask

    // Show seq[0..n-1]: each LED lit 3 cycles, 2 dark cycles between LEDs.
    task automatic show_seq(input int n);
        for (int i = 0; i < n; i++) begin
            game_if.leds = seq[i];
            repeat (3) @(negedge clock);
            game_if.leds = 4'b0000;
            if (i < n - 1) repeat (2) @(negedge clock);
        end
    endtask

    // Advance (bounded) until botoes is nonzero; gap counts sampled edges.
    task automatic wait_press(input string tag, input logic [3:0] exp);
        while (game_if.botoes == 4'b0000 && gap < 300) begin
            @(negedge clock);
            gap++;
        end
        check(tag, game_if.botoes, exp);
    endtask

    // Measure how long the current press lasts; leaves gap=1 (first release sample).
    task automatic measure_press();
        int n = 0;
        pval   = game_if.botoes;
        pwidth = 1;
        while (n < 50) begin
            @(negedge clock);
            n++;
            if (game_if.botoes == pval) pwidth++;
            else break;
        end
        gap = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        iniciar         = 1'b0;
        inject_error    = 1'b0;
        error_round     = '0;
        game_if.leds    = 4'b0000;
        game_if.ganhou  = 1'b0;
        game_if.perdeu  = 1'b0;
        game_if.timeout = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_estado",    db_estado, 4'd0);
        check("rst_jogar",     game_if.jogar, 1'b0);
        check("rst_botoes",    game_if.botoes, 4'b0000);
        check("rst_ocupado",   ocupado, 1'b0);
        check("rst_fim",       fim, 1'b0);
        check("rst_resultado", resultado, 2'b00);
        reset = 1'b0;
        @(negedge clock);

        // Round 0, LED 0100, game wins after one round.
        start_game(jc);
        check("t1_jogar_width", jc, 2);
        check("t1_ocupado", ocupado, 1'b1);
        wait_state(4'd2, "t1_observe");
        check("t1_rodada", db_rodada, 0);
        seq[0] = 4'b0100;
        show_seq(1);
        gap = 0;
        wait_press("t1_press_val", 4'b0100);
        check("t1_settle_latency", gap, 4);
        measure_press();
        check("t1_press_width", pwidth, 2);
        @(negedge clock);
        check("t1_release", game_if.botoes, 4'b0000);
        game_if.ganhou = 1'b1;
        @(negedge clock);
        game_if.ganhou = 1'b0;
        check("t1_resultado", resultado, 2'b01);
        check("t1_fim", fim, 1'b1);
        check("t1_ocupado_done", ocupado, 1'b0);
        check("t1_estado_done", db_estado, 4'd8);

        // Error injection in round 0: LED 0001 replayed as 0010.
        inject_error = 1'b1;
        error_round  = 4'd0;
        start_game(jc);
        check("t2_resultado_clr", resultado, 2'b00);
        check("t2_fim_clr", fim, 1'b0);
        wait_state(4'd2, "t2_observe");
        seq[0] = 4'b0001;
        show_seq(1);
        gap = 0;
        wait_press("t2_inject_val", 4'b0010);
        game_if.perdeu = 1'b1;
        @(negedge clock);
        game_if.perdeu = 1'b0;
        inject_error   = 1'b0;
        check("t2_resultado", resultado, 2'b10);
        check("t2_botoes", game_if.botoes, 4'b0000);
        check("t2_estado", db_estado, 4'd8);

        // Three rounds: 0001, 1000, 0010.
        seq[0] = 4'b0001;
        seq[1] = 4'b1000;
        seq[2] = 4'b0010;
        start_game(jc);
        check("t3_jogar_width", jc, 2);
        for (int r = 0; r < 3; r++) begin
            wait_state(4'd2, "t3_observe");
            check("t3_rodada", db_rodada, r);
            show_seq(r + 1);
            gap = 0;
            for (int k = 0; k <= r; k++) begin
                wait_press("t3_press_val", seq[k]);
                if (k > 0) check("t3_release_gap", gap, 3);
                measure_press();
                check("t3_press_width", pwidth, 2);
            end
        end
        game_if.ganhou = 1'b1;
        @(negedge clock);
        game_if.ganhou = 1'b0;
        check("t3_resultado", resultado, 2'b01);

        // perdeu and timeout together mid-press: perdeu wins.
        start_game(jc);
        wait_state(4'd2, "t4_observe");
        seq[0] = 4'b0010;
        show_seq(1);
        gap = 0;
        wait_press("t4_press_val", 4'b0010);
        game_if.perdeu  = 1'b1;
        game_if.timeout = 1'b1;
        @(negedge clock);
        game_if.perdeu  = 1'b0;
        game_if.timeout = 1'b0;
        check("t4_resultado", resultado, 2'b10);
        check("t4_botoes", game_if.botoes, 4'b0000);

        // Non-one-hot LED sets sticky erro_leds.
        start_game(jc);
        wait_state(4'd2, "t5_observe");
        seq[0] = 4'b0110;
        show_seq(1);
        check("t5_erro_set", erro_leds, 1'b1);
        gap = 0;
        wait_press("t5_press_val", 4'b0110);
        game_if.perdeu = 1'b1;
        @(negedge clock);
        game_if.perdeu = 1'b0;
        check("t5_estado_done", db_estado, 4'd8);
        check("t5_erro_done", erro_leds, 1'b1);
        @(negedge clock);
        check("t5_erro_hold", erro_leds, 1'b1);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("t5_erro_clr", erro_leds, 1'b0);
        check("t5_estado_start", db_estado, 4'd1);

        // Asynchronous reset during a 1000 press.
        wait_state(4'd2, "t6_observe");
        seq[0] = 4'b1000;
        show_seq(1);
        gap = 0;
        wait_press("t6_press_val", 4'b1000);
        #2 reset = 1'b1;
        #1;
        check("t6_botoes",    game_if.botoes, 4'b0000);
        check("t6_jogar",     game_if.jogar, 1'b0);
        check("t6_ocupado",   ocupado, 1'b0);
        check("t6_fim",       fim, 1'b0);
        check("t6_resultado", resultado, 2'b00);
        check("t6_erro",      erro_leds, 1'b0);
        check("t6_rodada",    db_rodada, 0);
        check("t6_estado",    db_estado, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_game(jc);
        check("t6_restart_jogar", jc, 2);
        wait_state(4'd2, "t6_restart_observe");
        check("t6_restart_rodada", db_rodada, 0);
        seq[0] = 4'b0001;
        show_seq(1);
        gap = 0;
        wait_press("t6_restart_press", 4'b0001);
        game_if.ganhou = 1'b1;
        @(negedge clock);
        game_if.ganhou = 1'b0;
        check("t6_restart_resultado", resultado, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
